// File: rtl/lectura_rtc.sv
// lectura_rtc: read sequencer for the RTC parallel bus. It sends the transfer command,
// reads 11 BCD registers into shadows and commits them to the outputs in a single cycle.
module lectura_rtc #(
  parameter logic [11:0] TIMEOUT  = 12'h04a,
  parameter logic [7:0]  CMD_ADDR = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       leer,
  input  logic       bus_ack,
  input  logic [7:0] bus_data_in,
  output logic [7:0] address,
  output logic [7:0] data_out,
  output logic       wr_req,
  output logic       rd_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] dia_sem,
  output logic [7:0] num_sem,
  output logic [7:0] seg_t,
  output logic [7:0] min_t,
  output logic [7:0] hora_t
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CMD = 2'd1, S_RD = 2'd2, S_COMMIT = 2'd3} state_t;

  localparam logic [3:0] LAST_IDX = 4'd10;

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h27;
      4'd7:    reg_addr = 8'h28;
      4'd8:    reg_addr = 8'h31;
      4'd9:    reg_addr = 8'h32;
      4'd10:   reg_addr = 8'h33;
      default: reg_addr = 8'h00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:0] tmo_q, tmo_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q;
  logic        capture_d;
  logic        commit_d;
  logic [7:0]  shadow_q [11];
  logic [7:0]  value_q  [11];

  // Next-state and request/handshake decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    err_d     = err_q;
    capture_d = 1'b0;
    commit_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (leer) begin
          state_d = S_CMD;
          wr_d    = 1'b1;
          addr_d  = CMD_ADDR;
          dout_d  = 8'hF0;
          tmo_d   = 12'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (bus_ack) begin
          state_d = S_RD;
          wr_d    = 1'b0;
          dout_d  = 8'h00;
          idx_d   = 4'd0;
        end else if (tmo_q == TIMEOUT) begin
          state_d = S_IDLE;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          addr_d  = 8'h00;
          dout_d  = 8'h00;
        end else begin
          tmo_d = tmo_q + 12'd1;
        end
      end
      S_RD: begin
        // rd_q low here is the one-cycle gap that precedes every read
        if (!rd_q) begin
          rd_d   = 1'b1;
          tmo_d  = 12'd0;
          addr_d = reg_addr(idx_q);
        end else if (bus_ack) begin
          capture_d = 1'b1;
          rd_d      = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d  = S_COMMIT;
            done_d   = 1'b1;
            commit_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (tmo_q == TIMEOUT) begin
          state_d = S_IDLE;
          rd_d    = 1'b0;
          err_d   = 1'b1;
          addr_d  = 8'h00;
        end else begin
          tmo_d = tmo_q + 12'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        addr_d  = 8'h00;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, handshake registers, shadow capture and atomic commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      tmo_q   <= 12'd0;
      addr_q  <= 8'h00;
      dout_q  <= 8'h00;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        shadow_q[i] <= 8'h00;
        value_q[i]  <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
      if (capture_d) begin
        shadow_q[idx_q] <= bus_data_in;
      end
      // The last byte bypasses its shadow so data and done appear together
      if (commit_d) begin
        for (int i = 0; i < 10; i++) begin
          value_q[i] <= shadow_q[i];
        end
        value_q[10] <= bus_data_in;
      end
    end
  end

  assign address  = addr_q;
  assign data_out = dout_q;
  assign wr_req   = wr_q;
  assign rd_req   = rd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;
  assign seg      = value_q[0];
  assign min      = value_q[1];
  assign hora     = value_q[2];
  assign dia      = value_q[3];
  assign mes      = value_q[4];
  assign anio     = value_q[5];
  assign dia_sem  = value_q[6];
  assign num_sem  = value_q[7];
  assign seg_t    = value_q[8];
  assign min_t    = value_q[9];
  assign hora_t   = value_q[10];

endmodule

// File: tb/tb_lectura_rtc.sv
// Self-checking bench for lectura_rtc: table-driven bursts against a bus model with
// per-address ack delays, plus directed timeout, re-trigger, reset and back-to-back cases.
module tb_lectura_rtc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       leer = 1'b0;
  logic       bus_ack = 1'b0;
  logic [7:0] bus_data_in = 8'h00;
  logic [7:0] address, data_out;
  logic       wr_req, rd_req, busy, done, error;
  logic [7:0] seg, min, hora, dia, mes, anio, dia_sem, num_sem, seg_t, min_t, hora_t;

  lectura_rtc dut (
    .clk(clk), .reset(reset), .leer(leer), .bus_ack(bus_ack), .bus_data_in(bus_data_in),
    .address(address), .data_out(data_out), .wr_req(wr_req), .rd_req(rd_req),
    .busy(busy), .done(done), .error(error),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .dia_sem(dia_sem), .num_sem(num_sem), .seg_t(seg_t), .min_t(min_t), .hora_t(hora_t)
  );

  always #5 clk = ~clk;

  localparam int TMO = 74;

  logic [7:0] tbl [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h31, 8'h32, 8'h33};

  // Bus model configuration (written only by the stimulus process)
  logic [7:0] data_add = 8'h01;
  int         ack_delay = 3;
  int         hang_addr = -1;
  int         slow_addr = -1;
  int         slow_delay = 0;
  bit         force_ack = 1'b0;

  // Bus model observations (written only by the bus model)
  logic [7:0] tx_addr [$];
  int         wr_n = 0, rd_n = 0, done_n = 0, proto_err = 0;
  int         req_cnt = 0, last_len = 0;
  logic [7:0] start_addr = 8'h00, last_addr = 8'h00;

  int checks = 0;
  int failures = 0;

  // Bus controller model: acks after a per-address delay and returns address + data_add
  always @(negedge clk) begin
    int d;
    if (done) done_n++;
    if (wr_req && rd_req) proto_err++;
    if (wr_req || rd_req) begin
      if (req_cnt == 0) begin
        tx_addr.push_back(address);
        start_addr = address;
        if (wr_req) wr_n++; else rd_n++;
      end else if (address !== start_addr) begin
        proto_err++;
      end
      if (wr_req && (address !== 8'hF0 || data_out !== 8'hF0)) proto_err++;
      if (rd_req && data_out !== 8'h00) proto_err++;
      d = (int'(address) == slow_addr) ? slow_delay : ack_delay;
      if (int'(address) != hang_addr && req_cnt == d) begin
        bus_ack = 1'b1;
        bus_data_in = address + data_add;
      end else begin
        bus_ack = 1'b0;
        bus_data_in = 8'h00;
      end
      req_cnt++;
    end else begin
      if (req_cnt != 0) begin
        last_len = req_cnt;
        last_addr = start_addr;
      end
      req_cnt = 0;
      bus_ack = force_ack;
      bus_data_in = force_ack ? 8'hA5 : 8'h00;
    end
  end

  function automatic logic [7:0] out_of(input int i);
    case (i)
      0: return seg;      1: return min;      2: return hora;   3: return dia;
      4: return mes;      5: return anio;     6: return dia_sem; 7: return num_sem;
      8: return seg_t;    9: return min_t;    10: return hora_t;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, int'(busy), 0);
  endtask

  task automatic wait_rd(input logic [7:0] a, input string name);
    int n = 0;
    while (!(rd_req && address == a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait_rd"}, int'(rd_req && address == a), 1);
  endtask

  task automatic run_burst(input int budget, input string name);
    @(negedge clk) leer = 1'b1;
    @(negedge clk) leer = 1'b0;
    wait_idle(budget, name);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] add;
    int         delay;
    logic [7:0] exp [11];
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base_tx, base_wr, base_rd, base_done, cyc, idle_cyc;
    int stamps [$];

    vecs[0].add = 8'h01; vecs[0].delay = 3;
    vecs[0].exp = '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h32, 8'h33, 8'h34};
    vecs[1].add = 8'h00; vecs[1].delay = 0;
    vecs[1].exp = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h31, 8'h32, 8'h33};
    vecs[2].add = 8'hDE; vecs[2].delay = 1;
    vecs[2].exp = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0F, 8'h10, 8'h11};
    vecs[3].add = 8'h66; vecs[3].delay = 2;
    vecs[3].exp = '{8'h87, 8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h97, 8'h98, 8'h99};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_address", int'(address), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_req", int'({wr_req, rd_req}), 0);
    chk("rst_busy_done_err", int'({busy, done, error}), 0);
    chk("rst_seg", int'(seg), 0);
    chk("rst_hora_t", int'(hora_t), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven bursts
    for (int v = 0; v < 4; v++) begin
      data_add = vecs[v].add;
      ack_delay = vecs[v].delay;
      base_tx = tx_addr.size(); base_wr = wr_n; base_rd = rd_n; base_done = done_n;
      run_burst(400, "vec");
      chk($sformatf("vec%0d_done_cnt", v), done_n - base_done, 1);
      chk($sformatf("vec%0d_wr_cnt", v), wr_n - base_wr, 1);
      chk($sformatf("vec%0d_rd_cnt", v), rd_n - base_rd, 11);
      chk($sformatf("vec%0d_error", v), int'(error), 0);
      if (tx_addr.size() >= base_tx + 12) begin
        chk($sformatf("vec%0d_cmd_addr", v), int'(tx_addr[base_tx]), 8'hF0);
        for (int i = 0; i < 11; i++)
          chk($sformatf("vec%0d_rd_addr%0d", v, i), int'(tx_addr[base_tx + 1 + i]), int'(tbl[i]));
      end
      for (int i = 0; i < 11; i++)
        chk($sformatf("vec%0d_out%0d", v, i), int'(out_of(i)), int'(vecs[v].exp[i]));
    end

    // Timeout on 0x23: request held TIMEOUT+1 cycles (count 0..TIMEOUT), outputs kept
    hang_addr = 8'h23;
    base_rd = rd_n; base_done = done_n;
    run_burst(400, "tmo");
    chk("tmo_error", int'(error), 1);
    chk("tmo_no_done", done_n - base_done, 0);
    chk("tmo_rd_cnt", rd_n - base_rd, 3);
    chk("tmo_last_addr", int'(last_addr), 8'h23);
    chk("tmo_req_len", last_len, TMO + 1);
    chk("tmo_seg_kept", int'(seg), 8'h87);
    chk("tmo_hora_t_kept", int'(hora_t), 8'h99);
    hang_addr = -1;
    base_done = done_n;
    @(negedge clk) leer = 1'b1;
    @(negedge clk) leer = 1'b0;
    chk("tmo_err_clr", int'(error), 0);
    wait_idle(400, "tmo_recover");
    @(negedge clk);
    chk("tmo_recover_done", done_n - base_done, 1);
    chk("tmo_recover_min", int'(min), 8'h88);

    // leer re-asserted during the 0x25 read is ignored
    data_add = 8'h01; ack_delay = 3;
    base_tx = tx_addr.size(); base_done = done_n;
    @(negedge clk) leer = 1'b1;
    @(negedge clk) leer = 1'b0;
    wait_rd(8'h25, "mid");
    leer = 1'b1;
    repeat (3) @(negedge clk);
    leer = 1'b0;
    wait_idle(400, "mid");
    repeat (4) @(negedge clk);
    chk("mid_tx_cnt", tx_addr.size() - base_tx, 12);
    chk("mid_done_cnt", done_n - base_done, 1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_seg", int'(seg), 8'h22);

    // Asynchronous reset mid-cycle during the 0x27 read
    @(negedge clk) leer = 1'b1;
    @(negedge clk) leer = 1'b0;
    wait_rd(8'h27, "arst");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_rd_req", int'(rd_req), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_address", int'(address), 0);
    chk("arst_seg", int'(seg), 0);
    chk("arst_num_sem", int'(num_sem), 0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_stay_idle", int'({busy, wr_req, rd_req}), 0);

    // Ack on 0x31 exactly at the timeout count is a success
    slow_addr = 8'h31; slow_delay = TMO; ack_delay = 1;
    base_done = done_n;
    run_burst(600, "edge");
    chk("edge_error", int'(error), 0);
    chk("edge_done", done_n - base_done, 1);
    chk("edge_seg_t", int'(seg_t), 8'h32);
    chk("edge_hora_t", int'(hora_t), 8'h34);
    slow_addr = -1;

    // Spurious ack while idle
    base_done = done_n; base_tx = tx_addr.size();
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_busy", int'(busy), 0);
    chk("spur_no_done", done_n - base_done, 0);
    chk("spur_no_tx", tx_addr.size() - base_tx, 0);
    chk("spur_seg", int'(seg), 8'h22);

    // leer held high: back-to-back bursts, 25 cycles apart with one idle cycle between
    data_add = 8'h00; ack_delay = 0;
    cyc = 0; idle_cyc = 0;
    leer = 1'b1;
    while (stamps.size() < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) stamps.push_back(cyc);
      else if (stamps.size() == 1 && !busy) idle_cyc++;
    end
    leer = 1'b0;
    wait_idle(100, "b2b");
    chk("b2b_done_cnt", stamps.size(), 3);
    if (stamps.size() == 3) begin
      chk("b2b_period01", stamps[1] - stamps[0], 25);
      chk("b2b_period12", stamps[2] - stamps[1], 25);
    end
    chk("b2b_idle_gap", idle_cyc, 1);
    chk("b2b_seg", int'(seg), 8'h21);

    chk("protocol_errors", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
